// File: rtl/flash_arbiter.sv
// flash_arbiter: round-robin sharing of the QSPI flash core between the cartridge bus (A) and the controller CPU (B).
// Define FLASH_ARB_TIMEOUT_EN to add a strobe-to-ack watchdog that completes the access with err=1.
module flash_arbiter #(
    parameter bit A_CFG_EN = 1'b0,
    parameter int TIMEOUT  = 1024
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_a_rq,
    input  logic        i_b_rq,
    input  logic        i_a_we,
    input  logic        i_b_we,
    input  logic        i_a_cfg,
    input  logic        i_b_cfg,
    input  logic [31:0] i_a_address,
    input  logic [31:0] i_b_address,
    input  logic [31:0] i_a_data,
    input  logic [31:0] i_b_data,
    output logic        o_a_ack,
    output logic        o_b_ack,
    output logic        o_a_err,
    output logic        o_b_err,
    output logic [31:0] o_a_data,
    output logic [31:0] o_b_data,
    output logic        o_wb_cyc,
    output logic        o_wb_stb,
    output logic        o_cfg_stb,
    output logic        o_wb_we,
    output logic [30:0] o_wb_addr,
    output logic [31:0] o_wb_data,
    input  logic        i_wb_ack,
    input  logic        i_wb_stall,
    input  logic [31:0] i_wb_data
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t      state;
    logic        last_grant;
    logic        mask_a, mask_b;
    logic        req_a, req_b, pick_valid, pick_b, reject;
    logic        sel_we, sel_cfg;
    logic [31:0] sel_address, sel_data;
    logic        finish, fin_err, fin_b;
    logic [31:0] fin_data;
    logic        timeout_hit;
    logic        unused_addr_lsb;

    assign unused_addr_lsb = sel_address[0];

`ifdef FLASH_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] tmo_cnt;

    // Counts every cycle the core owns the transaction; idle time resets it before the next issue.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n)
            tmo_cnt <= '0;
        else if (state == IDLE)
            tmo_cnt <= '0;
        else if (state == ISSUE || state == WAIT)
            tmo_cnt <= tmo_cnt + 1'b1;
    end

    assign timeout_hit = (state == ISSUE || state == WAIT) && (tmo_cnt == TMO_LAST);
`else
    localparam int UNUSED_TIMEOUT = TIMEOUT;
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        req_a       = i_a_rq & ~mask_a;
        req_b       = i_b_rq & ~mask_b;
        pick_valid  = req_a | req_b;
        // On a tie the port that did not win last time is chosen.
        pick_b      = req_b & (~req_a | ~last_grant);
        sel_we      = pick_b ? i_b_we      : i_a_we;
        sel_cfg     = pick_b ? i_b_cfg     : i_a_cfg;
        sel_address = pick_b ? i_b_address : i_a_address;
        sel_data    = pick_b ? i_b_data    : i_a_data;
        reject      = ~pick_b & i_a_cfg & ~A_CFG_EN;

        finish   = 1'b0;
        fin_err  = 1'b0;
        fin_data = i_wb_data;
        fin_b    = last_grant;
        case (state)
            IDLE: begin
                fin_b = pick_b;
                if (pick_valid && reject) begin
                    finish   = 1'b1;
                    fin_err  = 1'b1;
                    fin_data = '0;
                end
            end
            ISSUE: begin
                if (!i_wb_stall && i_wb_ack) begin
                    finish = 1'b1;
                end else if (timeout_hit) begin
                    finish   = 1'b1;
                    fin_err  = 1'b1;
                    fin_data = '0;
                end
            end
            WAIT: begin
                if (i_wb_ack) begin
                    finish = 1'b1;
                end else if (timeout_hit) begin
                    finish   = 1'b1;
                    fin_err  = 1'b1;
                    fin_data = '0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            mask_a     <= 1'b0;
            mask_b     <= 1'b0;
            o_a_ack    <= 1'b0;
            o_b_ack    <= 1'b0;
            o_a_err    <= 1'b0;
            o_b_err    <= 1'b0;
            o_a_data   <= '0;
            o_b_data   <= '0;
            o_wb_cyc   <= 1'b0;
            o_wb_stb   <= 1'b0;
            o_cfg_stb  <= 1'b0;
            o_wb_we    <= 1'b0;
            o_wb_addr  <= '0;
            o_wb_data  <= '0;
        end else begin
            o_a_ack <= 1'b0;
            o_b_ack <= 1'b0;
            mask_a  <= 1'b0;
            mask_b  <= 1'b0;
            if (state == IDLE && pick_valid)
                last_grant <= pick_b;

            if (finish) begin
                state     <= DONE;
                o_wb_cyc  <= 1'b0;
                o_wb_stb  <= 1'b0;
                o_cfg_stb <= 1'b0;
                if (fin_b) begin
                    o_b_ack  <= 1'b1;
                    o_b_err  <= fin_err;
                    o_b_data <= fin_data;
                end else begin
                    o_a_ack  <= 1'b1;
                    o_a_err  <= fin_err;
                    o_a_data <= fin_data;
                end
            end else begin
                case (state)
                    IDLE: begin
                        if (pick_valid) begin
                            state     <= ISSUE;
                            o_wb_cyc  <= 1'b1;
                            o_wb_stb  <= ~sel_cfg;
                            o_cfg_stb <= sel_cfg;
                            o_wb_we   <= sel_we;
                            o_wb_addr <= sel_address[31:1];
                            o_wb_data <= sel_data;
                        end
                    end
                    ISSUE: begin
                        if (!i_wb_stall) begin
                            state     <= WAIT;
                            o_wb_stb  <= 1'b0;
                            o_cfg_stb <= 1'b0;
                        end
                    end
                    WAIT: ;
                    DONE: begin
                        // A registered requester may still show rq for one cycle after its ack.
                        state  <= IDLE;
                        mask_a <= ~last_grant;
                        mask_b <= last_grant;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_flash_arbiter.sv
// tb_flash_arbiter: randomized scoreboard bench for flash_arbiter with a stub flash core and per-port expectation queues.
`timescale 1ns/1ps
module tb_flash_arbiter;

    localparam int TIMEOUT = 16;

    logic        i_clk = 1'b0;
    logic        i_reset_n = 1'b0;
    logic        i_a_rq = 1'b0, i_b_rq = 1'b0;
    logic        i_a_we = 1'b0, i_b_we = 1'b0;
    logic        i_a_cfg = 1'b0, i_b_cfg = 1'b0;
    logic [31:0] i_a_address = '0, i_b_address = '0;
    logic [31:0] i_a_data = '0, i_b_data = '0;
    logic        o_a_ack, o_b_ack, o_a_err, o_b_err;
    logic [31:0] o_a_data, o_b_data;
    logic        o_wb_cyc, o_wb_stb, o_cfg_stb, o_wb_we;
    logic [30:0] o_wb_addr;
    logic [31:0] o_wb_data;
    logic        i_wb_ack = 1'b0, i_wb_stall = 1'b0;
    logic [31:0] i_wb_data = '0;

    always #5 i_clk = ~i_clk;

    flash_arbiter #(.A_CFG_EN(1'b0), .TIMEOUT(TIMEOUT)) dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n),
        .i_a_rq(i_a_rq), .i_b_rq(i_b_rq), .i_a_we(i_a_we), .i_b_we(i_b_we),
        .i_a_cfg(i_a_cfg), .i_b_cfg(i_b_cfg),
        .i_a_address(i_a_address), .i_b_address(i_b_address),
        .i_a_data(i_a_data), .i_b_data(i_b_data),
        .o_a_ack(o_a_ack), .o_b_ack(o_b_ack), .o_a_err(o_a_err), .o_b_err(o_b_err),
        .o_a_data(o_a_data), .o_b_data(o_b_data),
        .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_cfg_stb(o_cfg_stb), .o_wb_we(o_wb_we),
        .o_wb_addr(o_wb_addr), .o_wb_data(o_wb_data),
        .i_wb_ack(i_wb_ack), .i_wb_stall(i_wb_stall), .i_wb_data(i_wb_data)
    );

    typedef struct { logic err; logic chk_data; logic [31:0] data; } exp_t;
    typedef struct { logic we; logic cfg; logic [31:0] addr; logic [31:0] data; } req_t;

    exp_t        exp_a[$], exp_b[$];
    req_t        pend[2];
    int          ack_log[$];
    logic [31:0] mem[logic [30:0]];
    int          tests = 0, fails = 0;
    int          force_stall = -1, force_delay = -1;
    bit          never_ack = 1'b0;

    longint      cycle = 0, stb_start = 0, last_gap = 0;
    int          stb_run = 0, last_stb_len = 0, cyc_cycles = 0;
    logic [30:0] last_stb_addr = '0;
    logic        last_prev_cyc = 1'b0;

    // Stub core memory: directed tests plant values, everything else reads a fixed hash of the address.
    function automatic logic [31:0] core_value(input logic [30:0] a);
        if (mem.exists(a)) return mem[a];
        return {1'b0, a} ^ 32'h5A5A_A5A5;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int p, input logic we, input logic cfg,
                                 input logic [31:0] addr, input logic [31:0] data, output int lat);
        exp_t e;
        req_t r;
        int   n;
        r.we = we; r.cfg = cfg; r.addr = addr; r.data = data;
        e.err = (p == 0) && cfg;
`ifdef FLASH_ARB_TIMEOUT_EN
        if (never_ack) e.err = 1'b1;
`endif
        e.chk_data = e.err || !we;
        e.data     = e.err ? 32'h0 : core_value(addr[31:1]);
        @(posedge i_clk); #1;
        pend[p] = r;
        if (p == 0) begin
            exp_a.push_back(e);
            i_a_we = we; i_a_cfg = cfg; i_a_address = addr; i_a_data = data; i_a_rq = 1'b1;
        end else begin
            exp_b.push_back(e);
            i_b_we = we; i_b_cfg = cfg; i_b_address = addr; i_b_data = data; i_b_rq = 1'b1;
        end
        lat = -1;
        n = 0;
        while (n < 3000) begin
            @(negedge i_clk);
            n++;
            if ((p == 0 && o_a_ack) || (p == 1 && o_b_ack)) begin
                lat = n;
                break;
            end
        end
        if (lat < 0) checkOutput("ack wait bound", 32'd0, 32'd1);
        @(posedge i_clk); #1;
        if (p == 0) i_a_rq = 1'b0; else i_b_rq = 1'b0;
    endtask

    task automatic stepCore(output bit abort);
        @(posedge i_clk); #1;
        abort = !i_reset_n || !o_wb_cyc;
    endtask

    task automatic serve();
        int          p, n, d;
        bit          abort;
        logic [31:0] rd;
        p  = o_wb_addr[30] ? 1 : 0;
        n  = (force_stall >= 0) ? force_stall : int'($urandom_range(0, 3));
        d  = (force_delay >= 0) ? force_delay : int'($urandom_range(0, 3));
        rd = o_wb_we ? 32'h0 : core_value(o_wb_addr);
        checkOutput("wb we", {31'h0, o_wb_we}, {31'h0, pend[p].we});
        checkOutput("wb cfg_stb", {31'h0, o_cfg_stb}, {31'h0, pend[p].cfg});
        checkOutput("wb stb", {31'h0, o_wb_stb}, {31'h0, !pend[p].cfg});
        checkOutput("wb addr", {1'b0, o_wb_addr}, {1'b0, pend[p].addr[31:1]});
        if (pend[p].we) checkOutput("wb wdata", o_wb_data, pend[p].data);
        if (p == 0) checkOutput("A cfg strobe reached core", {31'h0, o_cfg_stb}, 32'h0);
        i_wb_stall = (n > 0);
        for (int k = 0; k < n; k++) begin
            stepCore(abort);
            if (abort) return;
            i_wb_stall = (k < n - 1);
        end
        if (d == 0 && !never_ack) begin
            i_wb_ack = 1'b1; i_wb_data = rd;
        end
        stepCore(abort);
        i_wb_ack = 1'b0;
        if (abort || (d == 0 && !never_ack)) return;
        if (never_ack) begin
            for (int k = 0; k < 3000; k++) begin
                stepCore(abort);
                if (abort) return;
            end
            return;
        end
        for (int k = 1; k < d; k++) begin
            stepCore(abort);
            if (abort) return;
        end
        i_wb_ack = 1'b1; i_wb_data = rd;
        stepCore(abort);
        i_wb_ack = 1'b0;
    endtask

    initial begin
        forever begin
            @(posedge i_clk); #1;
            i_wb_ack = 1'b0;
            i_wb_stall = 1'b0;
            if (i_reset_n && o_wb_cyc && (o_wb_stb || o_cfg_stb)) serve();
        end
    end

    task automatic scoreAck(input int p, input logic err, input logic [31:0] data,
                            input logic [31:0] other_now, input logic [31:0] other_prev);
        exp_t e;
        ack_log.push_back(p);
        if ((p == 0 && exp_a.size() == 0) || (p == 1 && exp_b.size() == 0)) begin
            checkOutput(p == 0 ? "unexpected ack A" : "unexpected ack B", 32'd1, 32'd0);
            return;
        end
        e = (p == 0) ? exp_a.pop_front() : exp_b.pop_front();
        checkOutput(p == 0 ? "err A" : "err B", {31'h0, err}, {31'h0, e.err});
        if (e.chk_data) checkOutput(p == 0 ? "rdata A" : "rdata B", data, e.data);
        checkOutput(p == 0 ? "B data held on A ack" : "A data held on B ack", other_now, other_prev);
    endtask

    // Monitor: samples on the falling edge, pops the scoreboard on every ack and tracks bus timing.
    initial begin
        logic        prev_a_ack = 1'b0, prev_b_ack = 1'b0, prev_stb = 1'b0, prev_cyc = 1'b0, stb;
        logic [31:0] prev_a_data = '0, prev_b_data = '0;
        forever begin
            @(negedge i_clk);
            cycle++;
            stb = o_wb_stb | o_cfg_stb;
            if (i_reset_n) begin
                if (o_wb_stb && o_cfg_stb) checkOutput("both strobes high", 32'd1, 32'd0);
                if (prev_a_ack) checkOutput("ack A one cycle", {31'h0, o_a_ack}, 32'd0);
                if (prev_b_ack) checkOutput("ack B one cycle", {31'h0, o_b_ack}, 32'd0);
                if (stb && !prev_stb) begin
                    stb_start = cycle; stb_run = 0; last_stb_addr = o_wb_addr;
                end
                if (stb) stb_run++;
                else if (prev_stb) last_stb_len = stb_run;
                if (o_wb_cyc) cyc_cycles++;
                if (o_a_ack || o_b_ack) begin
                    last_gap = cycle - stb_start;
                    last_prev_cyc = prev_cyc;
                end
                if (o_a_ack) scoreAck(0, o_a_err, o_a_data, o_b_data, prev_b_data);
                if (o_b_ack) scoreAck(1, o_b_err, o_b_data, o_a_data, prev_a_data);
            end
            prev_a_ack = o_a_ack; prev_b_ack = o_b_ack; prev_stb = stb; prev_cyc = o_wb_cyc;
            prev_a_data = o_a_data; prev_b_data = o_b_data;
        end
    end

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " controls"}, {24'h0, o_a_ack, o_b_ack, o_a_err, o_b_err,
                                         o_wb_cyc, o_wb_stb, o_cfg_stb, o_wb_we}, 32'h0);
        checkOutput({tag, " wb_addr"}, {1'b0, o_wb_addr}, 32'h0);
        checkOutput({tag, " wb_data"}, o_wb_data, 32'h0);
        checkOutput({tag, " port data"}, o_a_data | o_b_data, 32'h0);
    endtask

    task automatic pulseReset();
        @(posedge i_clk); #2;
        i_reset_n = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        i_a_rq = 1'b0; i_b_rq = 1'b0; never_ack = 1'b0;
        exp_a.delete(); exp_b.delete(); ack_log.delete();
        i_reset_n = 1'b1;
    endtask

    initial begin
        int lat, lat_a, lat_b, lowcnt, cyc0, n;

        repeat (3) @(posedge i_clk);
        #1;
        checkAllZero("reset");
        i_reset_n = 1'b1;

        // Both ports hammer the core from reset: grants must alternate starting with A.
        fork
            for (int i = 0; i < 4; i++) applyStimulus(0, 1'b0, 1'b0, 32'h0000_1000 + 32'(i * 8), 32'h0, lat_a);
            for (int i = 0; i < 4; i++) applyStimulus(1, 1'b0, 1'b0, 32'h8000_2000 + 32'(i * 8), 32'h0, lat_b);
        join
        checkOutput("alternation ack count", ack_log.size(), 32'd8);
        for (int i = 0; i < 8 && i < ack_log.size(); i++) checkOutput("grant order", ack_log[i], 32'(i % 2));

        mem[31'h0008_0002] = 32'hDEAD_BEEF;
        force_stall = 3; force_delay = 1;
        applyStimulus(0, 1'b0, 1'b0, 32'h0010_0004, 32'h0, lat);
        checkOutput("stalled strobe length", last_stb_len, 32'd4);
        checkOutput("stalled strobe addr", {1'b0, last_stb_addr}, 32'h0008_0002);

        cyc0 = cyc_cycles;
        applyStimulus(0, 1'b1, 1'b1, 32'h0000_0100, 32'h0000_0055, lat);
        checkOutput("reject latency", lat, 32'd2);
        checkOutput("cyc during reject", cyc_cycles - cyc0, 32'd0);

        force_stall = 0; force_delay = 0;
        applyStimulus(1, 1'b1, 1'b1, 32'h8000_0200, 32'h0000_1100, lat);
        applyStimulus(1, 1'b0, 1'b0, 32'h8000_0300, 32'h0, lat);
        checkOutput("min core latency", lat, 32'd3);
        force_stall = -1; force_delay = -1;

        fork
            for (int i = 0; i < 25; i++) begin
                repeat ($urandom_range(0, 3)) @(posedge i_clk);
                applyStimulus(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
                              $urandom & 32'h7FFF_FFFF, $urandom, lat_a);
            end
            for (int i = 0; i < 25; i++) begin
                repeat ($urandom_range(0, 3)) @(posedge i_clk);
                applyStimulus(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
                              $urandom | 32'h8000_0000, $urandom, lat_b);
            end
        join
        checkOutput("A expectations drained", exp_a.size(), 32'd0);
        checkOutput("B expectations drained", exp_b.size(), 32'd0);

        force_stall = 0;
`ifdef FLASH_ARB_TIMEOUT_EN
        never_ack = 1'b1;
        applyStimulus(0, 1'b0, 1'b0, 32'h0000_4000, 32'h0, lat);
        never_ack = 1'b0;
        checkOutput("timeout strobe-to-ack", 32'(last_gap), 32'(TIMEOUT));
        checkOutput("cyc high before timeout ack", {31'h0, last_prev_cyc}, 32'd1);
`else
        never_ack = 1'b1;
        @(posedge i_clk); #1;
        pend[0].we = 1'b0; pend[0].cfg = 1'b0; pend[0].addr = 32'h0000_4000; pend[0].data = 32'h0;
        i_a_we = 1'b0; i_a_cfg = 1'b0; i_a_address = 32'h0000_4000; i_a_rq = 1'b1;
        repeat (5) @(negedge i_clk);
        lowcnt = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge i_clk);
            if (!o_wb_cyc) lowcnt++;
        end
        checkOutput("cyc held without timeout", lowcnt, 32'd0);
        pulseReset();
`endif
        force_stall = -1;

        // Reset during a B read that the core never answers.
        never_ack = 1'b1; force_stall = 0;
        @(posedge i_clk); #1;
        pend[1].we = 1'b0; pend[1].cfg = 1'b0; pend[1].addr = 32'h8000_0040; pend[1].data = 32'h0;
        i_b_we = 1'b0; i_b_cfg = 1'b0; i_b_address = 32'h8000_0040; i_b_rq = 1'b1;
        n = 0;
        do begin
            @(negedge i_clk);
            n++;
        end while (!(o_wb_cyc && !o_wb_stb && !o_cfg_stb) && n < 50);
        checkOutput("reached WAIT for B", {31'h0, o_wb_cyc}, 32'd1);
        #2;
        i_reset_n = 1'b0;
        #1;
        checkAllZero("async reset");
        repeat (2) @(posedge i_clk);
        #1;
        i_b_rq = 1'b0; never_ack = 1'b0; force_stall = -1;
        exp_a.delete(); exp_b.delete(); ack_log.delete();
        i_reset_n = 1'b1;
        fork
            applyStimulus(0, 1'b0, 1'b0, 32'h0000_0800, 32'h0, lat_a);
            applyStimulus(1, 1'b0, 1'b0, 32'h8000_0800, 32'h0, lat_b);
        join
        checkOutput("first grant after reset", (ack_log.size() > 0) ? 32'(ack_log[0]) : 32'd99, 32'd0);

        repeat (3) @(posedge i_clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #900000;
        fails++;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
